serial_packet_framer: RTL
=========================

# serial_packet_framer

Parametrised packet framer between the result RAM and the UART transmitter. On a transmit request it sends one frame to the UART byte interface: a header byte, a status byte, `DATA_LENGTH` bytes read sequentially from RAM, and an optional 8-bit checksum trailer. Unlike the fixed 22-byte framer, it adds the following:
- registered outputs;
- a UART busy hold-off;
- a one-deep pending request queue;
- a configurable RAM read latency;
- a completion pulse, which clears the best-nonce module.

## Interface
- `DATA_LENGTH`, default 22: payload bytes per frame. Legal range 1..2^`ADDR_WIDTH`; anything else is an elaboration error.
- `ADDR_WIDTH`, default 5: RAM address width.
- `RAM_LATENCY`, default 1: RAM read latency in cycles, 0 or 1.
- `CHECKSUM_EN`, default 1: 1 appends the checksum byte; 0 omits it.
- `clk_i` input 1: single clock, rising edge.
- `rst_ni` input 1: asynchronous, active-low reset.
- `transmit_i` input 1: frame request, sampled each cycle.
- `header_byte_i` input 8: header value, latched at frame start.
- `status_byte_i` input 8: status value, latched at frame start.
- `tx_busy_i` input 1: UART busy. The UART asserts it in the cycle after a strobe.
- `new_tx_data_o` output 1: one-cycle byte strobe to the UART.
- `tx_byte_o` output 8: byte to send, valid while `new_tx_data_o`=1.
- `ram_addr_o` output `ADDR_WIDTH`: RAM read address.
- `ram_i` input 8: RAM read data.
- `busy_o` output 1: a frame is in progress.
- `done_o` output 1: one-cycle end-of-frame pulse. It also drives the best-nonce module reset.

## Operation
- State machine: IDLE, HEADER, STATUS, DATA, CHECKSUM, DONE.
- IDLE:
  - On `transmit_i`=1, latch header and status, clear the checksum accumulator, set `ram_addr_o`=0, set `busy_o`=1, and go to HEADER.
- Issue rule, applying in HEADER, STATUS, DATA and CHECKSUM:
  - A byte is issued at an edge where hold-off=0 and `tx_busy_i`=0.
  - Issuing registers `tx_byte_o` and `new_tx_data_o`=1, and sets hold-off.
  - Hold-off clears at the next edge. `tx_busy_i` is ignored while hold-off is set.
- Per-state actions:
  - HEADER: issue the latched header, then go to STATUS.
  - STATUS: issue the latched status, then go to DATA. The accumulator becomes the status byte.
  - DATA:
    - Issue `ram_i`, which is the data at the current `ram_addr_o`, and add it to the accumulator mod 256.
    - If `ram_addr_o`=`DATA_LENGTH`-1, go to CHECKSUM when `CHECKSUM_EN`=1, otherwise go to DONE.
    - Otherwise increment `ram_addr_o` on the issue edge.
  - CHECKSUM: issue the accumulator, i.e. the sum mod 256 of the status byte and all data bytes; the header is excluded. Then go to DONE.
  - DONE:
    - Assert `done_o` for one cycle and set `ram_addr_o`=0.
    - If a request is pending, clear it and start a new frame (relatch inputs, go to HEADER, `busy_o` stays 1).
    - Otherwise go to IDLE with `busy_o`=0.
- RAM timing: `ram_addr_o` changes only on issue edges, and the next issue is at least 2 cycles later. `RAM_LATENCY` 0 and 1 therefore both present valid data without extra states.
- Pending request: `transmit_i`=1 while `busy_o`=1 sets a single pending flag. Further requests are merged into it. A request coinciding with the DONE cycle also sets pending.
- Address wrap: `ram_addr_o` never exceeds `DATA_LENGTH`-1. When `DATA_LENGTH`=2^`ADDR_WIDTH`, no overflow arithmetic is involved.

## Timing
- Reset (`rst_ni`=0, async) sets:
  - state IDLE, hold-off=0, pending=0, accumulator=0;
  - `new_tx_data_o`=0, `tx_byte_o`=0x00, `ram_addr_o`=0, `busy_o`=0, `done_o`=0.
- A reset mid-frame aborts the frame. No `done_o` is generated and no strobe glitch occurs.
- All outputs are registered; there is no combinational input-to-output path.
- Frame length is N = `DATA_LENGTH`+2+`CHECKSUM_EN` bytes.
- With the request sampled at edge k and `tx_busy_i`=0 whenever it is sampled:
  - strobes occur at edges k+1, k+3, …, k+2N-1;
  - `done_o` is high in the cycle starting at edge k+2N;
  - `busy_o` falls at edge k+2N+1.
- Back-to-back: with a request pending, the next header strobe occurs at edge k+2N+1.
- UART stall: each cycle `tx_busy_i`=1 after hold-off delays the next strobe by exactly one cycle. `tx_byte_o` holds its last value.

## Test plan
- Single frame, idle sink (busy pulses for 1 cycle after each strobe), header 0xA5, status 0x01, RAM[i]=i, default parameters -> 25 strobes carrying A5, 01, 00..15, then checksum 0xE8 (=(1+231) mod 256). `done_o` pulses once; `busy_o` is high for 51 cycles.
- UART stall: hold `tx_busy_i`=1 for 10 cycles after each strobe -> strobe spacing is 11 cycles, byte order is unchanged, and there is never a strobe while busy.
- Pending request: pulse `transmit_i` twice during a frame and once in its DONE cycle -> exactly two frames, with the second header strobe 1 cycle after `done_o`.
- Variants:
  - `CHECKSUM_EN`=0, `DATA_LENGTH`=32, `ADDR_WIDTH`=5 -> 34 bytes; `ram_addr_o` reaches 31 and returns to 0; no checksum byte.
  - `RAM_LATENCY`=0 and 1 -> identical byte streams.
- Reset mid-frame: assert `rst_ni`=0 asynchronously after the 5th strobe -> outputs go to their reset values immediately, no `done_o` is generated, and a fresh request then produces a complete correct frame.

Source files
------------

// File: rtl/serial_packet_framer.sv
// Packet framer between the result RAM and the UART byte interface.
// Sends header, status, DATA_LENGTH RAM bytes and an optional additive checksum.
// Every byte strobe is followed by at least one hold-off cycle, so the RAM
// address is always stable for two edges before its data is used.
module serial_packet_framer #(
    parameter int unsigned DATA_LENGTH = 22,
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned RAM_LATENCY = 1,
    parameter int unsigned CHECKSUM_EN = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  transmit_i,
    input  logic [7:0]            header_byte_i,
    input  logic [7:0]            status_byte_i,
    input  logic                  tx_busy_i,
    output logic                  new_tx_data_o,
    output logic [7:0]            tx_byte_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    input  logic [7:0]            ram_i,
    output logic                  busy_o,
    output logic                  done_o
);

    // Reject parameter values the datapath cannot honour.
    if (DATA_LENGTH < 1 || DATA_LENGTH > (1 << ADDR_WIDTH)) begin : g_bad_length
        $error("DATA_LENGTH must be in 1..2**ADDR_WIDTH");
    end
    if (RAM_LATENCY > 1) begin : g_bad_latency
        $error("RAM_LATENCY must be 0 or 1");
    end
    if (CHECKSUM_EN > 1) begin : g_bad_checksum
        $error("CHECKSUM_EN must be 0 or 1");
    end

    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DATA_LENGTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StHeader,
        StStatus,
        StData,
        StChecksum,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [7:0]            header_q, header_d;
    logic [7:0]            status_q, status_d;
    logic [7:0]            acc_q, acc_d;
    logic [7:0]            tx_byte_q, tx_byte_d;
    logic                  new_tx_q, new_tx_d;
    logic                  holdoff_q, holdoff_d;
    logic                  pending_q, pending_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    logic in_frame;
    logic issue;
    logic last_addr;
    logic start;

    assign in_frame  = (state_q == StHeader) || (state_q == StStatus) ||
                       (state_q == StData)   || (state_q == StChecksum);
    // tx_busy_i is only meaningful once the hold-off cycle has passed.
    assign issue     = in_frame && !holdoff_q && !tx_busy_i;
    assign last_addr = (addr_q == LastAddr);
    // A request seen in the DONE cycle chains straight into the next frame.
    assign start     = ((state_q == StIdle) && transmit_i) ||
                       ((state_q == StDone) && (pending_q || transmit_i));

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: each sending state advances on its issue edge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (transmit_i) state_d = StHeader;
            StHeader:   if (issue) state_d = StStatus;
            StStatus:   if (issue) state_d = StData;
            StData: begin
                if (issue && last_addr) begin
                    state_d = (CHECKSUM_EN != 0) ? StChecksum : StDone;
                end
            end
            StChecksum: if (issue) state_d = StDone;
            StDone:     state_d = start ? StHeader : StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Output and datapath next-state: byte selection, checksum, address, flags.
    always_comb begin
        header_d  = header_q;
        status_d  = status_q;
        acc_d     = acc_q;
        tx_byte_d = tx_byte_q;
        new_tx_d  = issue;
        holdoff_d = issue;
        addr_d    = addr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pending_d = pending_q | (in_frame & transmit_i);
        unique case (state_q)
            StIdle: busy_d = transmit_i;
            StHeader: begin
                if (issue) tx_byte_d = header_q;
            end
            StStatus: begin
                if (issue) begin
                    tx_byte_d = status_q;
                    acc_d     = status_q;
                end
            end
            StData: begin
                if (issue) begin
                    tx_byte_d = ram_i;
                    acc_d     = acc_q + ram_i;
                    if (!last_addr) addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            StChecksum: begin
                if (issue) tx_byte_d = acc_q;
            end
            StDone: begin
                done_d    = 1'b1;
                addr_d    = '0;
                pending_d = 1'b0;
            end
            default: ;
        endcase
        if (start) begin
            header_d = header_byte_i;
            status_d = status_byte_i;
            acc_d    = '0;
            addr_d   = '0;
            busy_d   = 1'b1;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            header_q  <= '0;
            status_q  <= '0;
            acc_q     <= '0;
            tx_byte_q <= '0;
            new_tx_q  <= 1'b0;
            holdoff_q <= 1'b0;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            addr_q    <= '0;
        end else begin
            header_q  <= header_d;
            status_q  <= status_d;
            acc_q     <= acc_d;
            tx_byte_q <= tx_byte_d;
            new_tx_q  <= new_tx_d;
            holdoff_q <= holdoff_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            addr_q    <= addr_d;
        end
    end

    assign new_tx_data_o = new_tx_q;
    assign tx_byte_o     = tx_byte_q;
    assign ram_addr_o    = addr_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule
